fwd_hazard_unit: RTL and testbench

//  Parametrised operand-forwarding and load-use hazard unit for the CPU pipeline.
//  - Keeps its own shadow table of producers downstream of ID (EX, MEM, WB, ...).
//  - Drives forwarding selects for the instruction in EX.
//  - Raises a load-use stall for the instruction in ID.
//  - Counts stall cycles.
//  - Generalises the 2-source, MEM/WB-only forward logic to NSRC sources, NSTAGE producer stages and a configurable load-data stage.

---
 rtl/fwd_pkg.sv | 20 ++
 rtl/fwd_match.sv | 35 +++
 rtl/fwd_hazard_unit.sv | 113 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared constants for the operand-forwarding / load-use hazard unit.
// A table entry is a flat vector: {rd, load, regw, valid} from MSB to LSB.
package fwd_pkg;

  localparam int unsigned FWD_RF = 0;

  localparam int unsigned E_VALID = 0;
  localparam int unsigned E_REGW  = 1;
  localparam int unsigned E_LOAD  = 2;
  localparam int unsigned E_RD    = 3;

  function automatic int unsigned sw_of(input int unsigned nstage);
    return unsigned'($clog2(nstage + 1));
  endfunction

  function automatic int unsigned entry_w(input int unsigned aw);
    return E_RD + aw;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one source register against N table entries.
// The lowest-numbered (youngest) matching entry wins; x0 and unused sources never match.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned AW = 5,
  parameter int unsigned IW = 2,
  localparam int unsigned EW = entry_w(AW)
) (
  input  logic [AW-1:0]   reg_addr,
  input  logic            used,
  input  logic [N*EW-1:0] ents,
  output logic            hit_c,
  output logic [IW-1:0]   idx_c,
  output logic            load_c
);

  always_comb begin
    hit_c  = 1'b0;
    idx_c  = '0;
    load_c = 1'b0;
    // Scan oldest to youngest so the youngest match overwrites.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (used && (reg_addr != '0) &&
          ents[i*EW + E_VALID] && ents[i*EW + E_REGW] &&
          (ents[i*EW + E_RD +: AW] == reg_addr)) begin
        hit_c  = 1'b1;
        idx_c  = IW'(i);
        load_c = ents[i*EW + E_LOAD];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit: shadow table of producers past ID,
// EX forwarding selects, ID load-use stall and a saturating stall-cycle counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned NSRC       = 2,
  parameter int unsigned NSTAGE     = 2,
  parameter int unsigned AW         = 5,
  parameter int unsigned LOAD_AVAIL = 2,
  parameter int unsigned CW         = 16,
  localparam int unsigned SW = sw_of(NSTAGE)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_valid_i,
  input  logic [NSRC*AW-1:0] id_rs_i,
  input  logic [NSRC-1:0]    id_rs_used_i,
  input  logic [AW-1:0]      id_rd_i,
  input  logic               id_regw_i,
  input  logic               id_load_i,
  input  logic               hold_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic [NSRC*SW-1:0] ex_fwd_sel_o,
  output logic [NSRC-1:0]    ex_fwd_hit_o,
  output logic [CW-1:0]      stall_cnt_o
);

  localparam int unsigned EW = entry_w(AW);

  logic [EW-1:0]        tbl [NSTAGE+1];
  logic [NSRC*AW-1:0]   ex_rs;
  logic [NSRC-1:0]      ex_rs_used;
  logic [EW-1:0]        new_ent;
  logic [NSTAGE*EW-1:0] ex_ents;
  logic [NSTAGE*EW-1:0] id_ents;

  logic [NSRC-1:0] ex_hit;
  logic [NSRC-1:0] ex_ld;
  logic [SW-1:0]   ex_idx [NSRC];
  logic [NSRC-1:0] id_hit;
  logic [NSRC-1:0] id_ld;
  logic [SW-1:0]   id_idx [NSRC];
  logic [NSRC-1:0] id_stall;

  logic take_id;

  // EX forwards from entries 1..NSTAGE; ID stall looks at entries 0..NSTAGE-1.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_ents
    assign ex_ents[k*EW +: EW] = tbl[k+1];
    assign id_ents[k*EW +: EW] = tbl[k];
  end

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fwd_match #(.N(NSTAGE), .AW(AW), .IW(SW)) u_ex_match (
      .reg_addr (ex_rs[s*AW +: AW]),
      .used     (ex_rs_used[s] & tbl[0][E_VALID]),
      .ents     (ex_ents),
      .hit_c    (ex_hit[s]),
      .idx_c    (ex_idx[s]),
      .load_c   (ex_ld[s])
    );

    fwd_match #(.N(NSTAGE), .AW(AW), .IW(SW)) u_id_match (
      .reg_addr (id_rs_i[s*AW +: AW]),
      .used     (id_rs_used_i[s]),
      .ents     (id_ents),
      .hit_c    (id_hit[s]),
      .idx_c    (id_idx[s]),
      .load_c   (id_ld[s])
    );

    assign ex_fwd_sel_o[s*SW +: SW] = ex_hit[s] ? SW'(int'(ex_idx[s]) + 1) : SW'(FWD_RF);
    // A younger non-load producer of the same register masks an older load.
    assign id_stall[s] = id_hit[s] & id_ld[s] & ((int'(id_idx[s]) + 1) < int'(LOAD_AVAIL));

    a_load_reach: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(ex_hit[s] && ex_ld[s] && ((int'(ex_idx[s]) + 1) < int'(LOAD_AVAIL))));
  end

  assign ex_fwd_hit_o = ex_hit;
  assign stall_o      = id_valid_i & ~flush_i & (|id_stall);
  assign take_id      = id_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    new_ent                = '0;
    new_ent[E_VALID]       = 1'b1;
    new_ent[E_REGW]        = id_regw_i;
    new_ent[E_LOAD]        = id_load_i;
    new_ent[E_RD +: AW]    = id_rd_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k <= int'(NSTAGE); k++) tbl[k] <= '0;
      ex_rs       <= '0;
      ex_rs_used  <= '0;
      stall_cnt_o <= '0;
    end else if (!hold_i) begin
      for (int k = int'(NSTAGE); k >= 1; k--) tbl[k] <= tbl[k-1];
      if (take_id) begin
        tbl[0]     <= new_ent;
        ex_rs      <= id_rs_i;
        ex_rs_used <= id_rs_used_i;
      end else begin
        tbl[0]     <= '0;
        ex_rs_used <= '0;
      end
      if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CW'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: instance a uses the defaults, instance b uses NSTAGE=3, LOAD_AVAIL=3.
// Both see the same ID stream; expected values are hand-derived per instance.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [9:0] id_rs = '0;
  logic [1:0] id_used = '0;
  logic [4:0] id_rd = '0;
  logic       id_regw = 1'b0;
  logic       id_load = 1'b0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;

  logic        stall_a, stall_b;
  logic [3:0]  sel_a, sel_b;
  logic [1:0]  hit_a, hit_b;
  logic [15:0] cnt_a, cnt_b;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_a (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rs_used_i(id_used), .id_rd_i(id_rd), .id_regw_i(id_regw),
    .id_load_i(id_load), .hold_i(hold), .flush_i(flush),
    .stall_o(stall_a), .ex_fwd_sel_o(sel_a), .ex_fwd_hit_o(hit_a), .stall_cnt_o(cnt_a)
  );

  fwd_hazard_unit #(.NSTAGE(3), .LOAD_AVAIL(3)) u_b (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rs_used_i(id_used), .id_rd_i(id_rd), .id_regw_i(id_regw),
    .id_load_i(id_load), .hold_i(hold), .flush_i(flush),
    .stall_o(stall_b), .ex_fwd_sel_o(sel_b), .ex_fwd_hit_o(hit_b), .stall_cnt_o(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd,
                       input logic regw, input logic ld);
    id_valid = v;
    id_rs    = {rs1, rs0};
    id_used  = used;
    id_rd    = rd;
    id_regw  = regw;
    id_load  = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    #12;
    chk("rst_sel_a", 32'(sel_a), 32'h0);
    chk("rst_hit_a", 32'(hit_a), 32'h0);
    chk("rst_stall_a", 32'(stall_a), 32'h0);
    chk("rst_cnt_b", 32'(cnt_b), 32'h0);
    rst = 1'b1;
    tick();

    // ALU chain: add x5; sub uses x5; or uses x5 one cycle later
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd3, 2'b11, 5'd6, 1'b1, 1'b0);
    chk("alu_nostall_a", 32'(stall_a), 32'h0);
    chk("alu_nostall_b", 32'(stall_b), 32'h0);
    tick();
    drive(1'b1, 5'd1, 5'd5, 2'b11, 5'd8, 1'b1, 1'b0);
    chk("alu_sel1_a", 32'(sel_a), 32'h1);
    chk("alu_hit1_a", 32'(hit_a), 32'h1);
    chk("alu_sel1_b", 32'(sel_b), 32'h1);
    tick();
    idle();
    chk("alu_sel2_a", 32'(sel_a), 32'h8);
    chk("alu_hit2_a", 32'(hit_a), 32'h2);
    chk("alu_sel2_b", 32'(sel_b), 32'h8);
    drain();

    // Double producer: youngest wins
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd11, 1'b1, 1'b0);
    tick();
    idle();
    chk("dbl_sel_a", 32'(sel_a), 32'h1);
    chk("dbl_sel_b", 32'(sel_b), 32'h1);
    drain();

    // Load-use: lw x7; add uses x7
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
    chk("lu_stall1_a", 32'(stall_a), 32'h1);
    chk("lu_stall1_b", 32'(stall_b), 32'h1);
    tick();
    chk("lu_stall2_a", 32'(stall_a), 32'h0);
    chk("lu_stall2_b", 32'(stall_b), 32'h1);
    chk("lu_cnt1_a", 32'(cnt_a), 32'h1);
    tick();
    chk("lu_sel_a", 32'(sel_a), 32'h2);
    chk("lu_hit_a", 32'(hit_a), 32'h1);
    chk("lu_stall3_b", 32'(stall_b), 32'h0);
    chk("lu_cnt2_b", 32'(cnt_b), 32'h2);
    tick();
    chk("lu_sel_b", 32'(sel_b), 32'h3);
    chk("lu_cnt_a", 32'(cnt_a), 32'h1);
    drain();

    // Flush during a would-be stall
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
    chk("fl_stall_a", 32'(stall_a), 32'h0);
    chk("fl_stall_b", 32'(stall_b), 32'h0);
    tick();
    flush = 1'b0;
    idle();
    chk("fl_bubble_a", 32'(hit_a), 32'h0);
    chk("fl_bubble_b", 32'(hit_b), 32'h0);
    chk("fl_cnt_b", 32'(cnt_b), 32'h2);
    drain();

    // x0 producer and unused source
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);
    chk("x0_nostall1_b", 32'(stall_b), 32'h0);
    tick();
    drive(1'b1, 5'd0, 5'd7, 2'b01, 5'd12, 1'b1, 1'b0);
    chk("x0_nostall2_a", 32'(stall_a), 32'h0);
    chk("x0_nostall2_b", 32'(stall_b), 32'h0);
    tick();
    idle();
    chk("x0_sel_a", 32'(sel_a), 32'h0);
    chk("x0_sel_b", 32'(sel_b), 32'h0);
    drain();

    // Hold freezes table and counter while a stall is pending
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd5, 5'd7, 2'b11, 5'd10, 1'b1, 1'b0);
    chk("hd_sel_a", 32'(sel_a), 32'h1);
    chk("hd_stall_a", 32'(stall_a), 32'h1);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hd_frz_sel_a", 32'(sel_a), 32'h1);
      chk("hd_frz_stall_b", 32'(stall_b), 32'h1);
      chk("hd_frz_cnt_a", 32'(cnt_a), 32'h1);
      chk("hd_frz_cnt_b", 32'(cnt_b), 32'h2);
    end
    hold = 1'b0;
    tick();
    chk("hd_cnt_a", 32'(cnt_a), 32'h2);
    chk("hd_cnt_b", 32'(cnt_b), 32'h3);
    chk("hd_stall_a2", 32'(stall_a), 32'h0);
    chk("hd_stall_b2", 32'(stall_b), 32'h1);
    tick();
    chk("hd_sel2_a", 32'(sel_a), 32'h8);
    chk("hd_hit2_a", 32'(hit_a), 32'h2);
    chk("hd_cnt2_b", 32'(cnt_b), 32'h4);

    // Asynchronous reset mid-cycle with a loaded table
    #2;
    rst = 1'b0;
    #1;
    chk("mr_sel_a", 32'(sel_a), 32'h0);
    chk("mr_hit_a", 32'(hit_a), 32'h0);
    chk("mr_stall_b", 32'(stall_b), 32'h0);
    chk("mr_cnt_a", 32'(cnt_a), 32'h0);
    chk("mr_cnt_b", 32'(cnt_b), 32'h0);
    idle();
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
